// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioning front end.
// Pure definitions; no clocked logic.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned REPEAT_DELAY_DEF    = 50_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10_000_000;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_pulse_conditioner_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs; 2-cycle latency, no handshake.
// Both stages clear to 0 on reset so downstream logic starts from a released input.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Bouncing push-button -> one-cycle count request; pulse 2+DEBOUNCE_CYCLES cycles after a stable press.
// Define AUTO_REPEAT_EN to add held-button repeat pulses; ports are identical in both builds.
module button_pulse_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic countup,
    output logic btn_level,
    output logic busy
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_pulse_conditioner: cycle parameters must all be >= 1");
    end

    logic       s;
    btn_state_t state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic       countup_q, countup_d;
    logic       rep_pulse;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_in),
        .q_o   (s)
    );

    // Both wait states count the sample that triggered entry, so press and release need the same run length.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        countup_d = rep_pulse;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = DB_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    countup_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = DB_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RP_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

    logic [RP_W-1:0] rep_q, rep_d;
    logic            rep_first_q, rep_first_d;
    logic [RP_W-1:0] rep_target;

    // Timer only advances while PRESSED persists, so any bounce through RELEASE_WAIT re-arms the long delay.
    always_comb begin
        rep_target  = rep_first_q ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_PERIOD - 1);
        rep_d       = '0;
        rep_first_d = 1'b1;
        rep_pulse   = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rep_q == rep_target) begin
                rep_pulse   = 1'b1;
                rep_first_d = 1'b0;
            end else begin
                rep_d       = rep_q + RP_W'(1);
                rep_first_d = rep_first_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            countup_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            countup_q <= countup_d;
        end
    end

    assign countup   = countup_q;
    assign btn_level = (state_q == PRESSED)    || (state_q == RELEASE_WAIT);
    assign busy      = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);

endmodule
